// File: rtl/serial_word_receiver.sv
// LSB-first framed serial receiver (start, WIDTH data, optional even parity, stop)
// feeding a one-entry valid/ready output register. Optional macro: PARITY_CHECK_EN.
module serial_word_receiver #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             sdata,
    input  logic             svalid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd2} state_t;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;
    logic               busy_q, busy_d;
    logic               good_frame;
`ifdef PARITY_CHECK_EN
    logic               par_bad_q, par_bad_d;
    logic               parity_err_q, parity_err_d;
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
`ifdef PARITY_CHECK_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Frame sequencing, word assembly and output register handshake
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        good_frame   = 1'b0;
`ifdef PARITY_CHECK_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif

        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (svalid && !sdata) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (svalid) begin
                    shift_d = {sdata, shift_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        cnt_d = '0;
`ifdef PARITY_CHECK_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            PARITY: begin
                if (svalid) begin
                    par_bad_d = ^{shift_q, sdata};
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (svalid) begin
                    state_d = IDLE;
                    if (!sdata) begin
                        frame_err_d = 1'b1;
`ifdef PARITY_CHECK_EN
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
`endif
                    end else begin
                        good_frame = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A full register is only replaced if it is being drained this cycle
        if (good_frame) begin
            if (!dout_valid_q || dout_ready) begin
                dout_d       = shift_q;
                dout_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;
`ifdef PARITY_CHECK_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_receiver.sv
// Self-checking bench for serial_word_receiver: frame vector table, consumer
// scoreboard, and hand-written overrun / mid-frame reset sequences.
module tb_serial_word_receiver;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         clear;
    logic         sdata;
    logic         svalid;
    logic         dout_ready;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         frame_err;
    logic         parity_err;
    logic         overrun;
    logic         busy;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    serial_word_receiver #(.WIDTH(W)) dut (
        .clk        (clk),
        .clear      (clear),
        .sdata      (sdata),
        .svalid     (svalid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         stop_bit;
        logic         par_bad;
        int           stall;
        logic         exp_valid;
        logic [W-1:0] exp_dout;
        logic         exp_fe;
        logic         exp_pe;
        logic         exp_ovr;
    } vec_t;

`ifdef PARITY_CHECK_EN
    localparam int N_VEC = 6;
`else
    localparam int N_VEC = 4;
`endif
    vec_t vecs[N_VEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic sd, input logic sv);
        sdata  = sd;
        svalid = sv;
        @(posedge clk);
        #1;
    endtask

    // Stall cycles carry the inverted bit so a stalled sample would corrupt the word
    task automatic send_bit(input logic b, input int stall, input logic in_frame);
        for (int s = 0; s < stall; s++) begin
            drive(~b, 1'b0);
            chk("stall_busy", 32'(busy), 32'(in_frame));
        end
        drive(b, 1'b1);
    endtask

    task automatic send_frame(input logic [W-1:0] data, input logic stop_bit,
                              input logic par_bad, input int stall,
                              input logic ready_data, input logic ready_stop,
                              input logic push);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        chk("idle_busy", 32'(busy), 32'd0);
        dout_ready = ready_data;
        send_bit(1'b0, stall, 1'b0);
        chk("start_busy", 32'(busy), 32'd1);
        for (int i = 0; i < int'(W); i++) send_bit(data[i], stall, 1'b1);
`ifdef PARITY_CHECK_EN
        send_bit((^data) ^ par_bad, stall, 1'b1);
`endif
        dout_ready = ready_stop;
        if (push) exp_q.push_back(data);
        send_bit(stop_bit, stall, 1'b1);
    endtask

    task automatic chk_after_stop(input string tag, input logic ev, input logic [W-1:0] ed,
                                  input logic efe, input logic epe, input logic eov);
        chk({tag, "_valid"}, 32'(dout_valid), 32'(ev));
        chk({tag, "_dout"}, 32'(dout), 32'(ed));
        chk({tag, "_flags"}, 32'({frame_err, parity_err, overrun}), 32'({efe, epe, eov}));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        drive(1'b1, 1'b1);
        chk({tag, "_pulse_end"}, 32'({frame_err, parity_err, overrun}), 32'd0);
    endtask

    // Consumer scoreboard: every word taken by the handshake must be the next expected one
    always @(negedge clk) begin
        if (!clear && dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_word", 32'(dout), 32'hFFFF_FFFF);
            end else begin
                chk("sb_word", 32'(dout), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        vecs[0] = '{4'hD, 1'b1, 1'b0, 0, 1'b1, 4'hD, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{4'hD, 1'b1, 1'b0, 1, 1'b1, 4'hD, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{4'h6, 1'b0, 1'b0, 0, 1'b0, 4'hD, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{4'hF, 1'b1, 1'b0, 0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0};
`ifdef PARITY_CHECK_EN
        vecs[4] = '{4'hD, 1'b1, 1'b1, 0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{4'h6, 1'b0, 1'b1, 0, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0};
`endif

        clear      = 1'b1;
        sdata      = 1'b1;
        svalid     = 1'b0;
        dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_flags", 32'({frame_err, parity_err, overrun}), 32'd0);
        clear = 1'b0;

        for (int v = 0; v < N_VEC; v++) begin
            send_frame(vecs[v].data, vecs[v].stop_bit, vecs[v].par_bad, vecs[v].stall,
                       1'b1, 1'b1,
                       !(vecs[v].exp_fe || vecs[v].exp_pe || vecs[v].exp_ovr));
            chk_after_stop($sformatf("vec%0d", v), vecs[v].exp_valid, vecs[v].exp_dout,
                           vecs[v].exp_fe, vecs[v].exp_pe, vecs[v].exp_ovr);
        end

        // Overrun: second word dropped while the first is held
        send_frame(4'h3, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk_after_stop("ovr_first", 1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
        send_frame(4'h5, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk_after_stop("ovr_drop", 1'b1, 4'h3, 1'b0, 1'b0, 1'b1);
        // Draining on the stop edge frees the slot for the new word
        send_frame(4'h5, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        dout_ready = 1'b1;
        chk_after_stop("ovr_drain", 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a frame
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        chk("pre_clear_busy", 32'(busy), 32'd1);
        clear = 1'b1;
        drive(1'b1, 1'b1);
        clear = 1'b0;
        chk("clear_busy", 32'(busy), 32'd0);
        chk("clear_valid", 32'(dout_valid), 32'd0);
        chk("clear_dout", 32'(dout), 32'd0);
        chk("clear_flags", 32'({frame_err, parity_err, overrun}), 32'd0);
        send_frame(4'hA, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1);
        chk_after_stop("post_clear", 1'b1, 4'hA, 1'b0, 1'b0, 1'b0);

        repeat (3) drive(1'b1, 1'b1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_word_receiver.md
# serial_word_receiver

Synchronous serial-in/parallel-out receiver: the far end of the shift-register serial link. Accepts an LSB-first framed bit stream (start bit, WIDTH data bits, optional even-parity bit, stop bit), one bit per qualified cycle. Each good frame is assembled into a WIDTH-bit word and presented on a one-entry valid/ready output register. Sits between the serial link and the parallel datapath consumer.

## Interface
- WIDTH, 4, data bits per frame (≥2)

- clk  input  1  rising-edge clock
- clear  input  1  synchronous reset, active-high
- sdata  input  1  serial line; idle level 1
- svalid  input  1  sdata is sampled only in cycles where svalid=1; svalid=0 stalls the FSM
- dout  output  WIDTH  received word, LSB = first data bit
- dout_valid  output  1  dout holds an unconsumed word
- dout_ready  input  1  consumer accepts dout when dout_valid & dout_ready
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0
- parity_err  output  1  one-cycle pulse: parity mismatch (0 when parity compiled out)
- overrun  output  1  one-cycle pulse: good frame completed while output register full
- busy  output  1  FSM not in IDLE

## Operation
- Reset (clear=1 at a clock edge): FSM→IDLE, bit counter=0, shift register=0, dout=0, dout_valid=0, all pulses 0, busy=0. Reset mid-frame aborts the frame with no flags.
- FSM states: IDLE, DATA, PARITY (compiled only with macro), STOP.
- IDLE: qualified sample sdata=0 → DATA, counter=0. sdata=1 or svalid=0 → stay.
- DATA: each qualified sample shifts sdata into MSB of shift register (right shift), counter+1; after WIDTH-th sample → PARITY (or STOP if compiled out). Result: first bit lands in bit 0.
- PARITY: one qualified sample; even parity: XOR of data bits and parity bit must be 0. → STOP.
- STOP: one qualified sample → IDLE.
  - sdata=0: frame_err pulse, word discarded (takes priority over parity_err; only frame_err pulses).
  - sdata=1, parity bad: parity_err pulse, word discarded.
  - sdata=1, parity ok: good frame.
- Good frame, output register empty, or full and dout_ready=1 this cycle: dout←word, dout_valid=1.
- Good frame, output full and dout_ready=0: word dropped, dout keeps old word, overrun pulse.
- Handshake: dout_valid & dout_ready with no incoming good frame → dout_valid=0; dout holds last value. dout stable while dout_valid=1 and not consumed.
- Back-to-back frames: STOP→IDLE, next start bit may be the very next qualified sample.

## Timing
- Frame length: WIDTH+2 qualified samples (WIDTH+3 with parity); idle cycles and svalid=0 cycles add no state change.
- dout/dout_valid/error pulses update at the clock edge that samples the stop bit (registered outputs, visible the cycle after stop bit presented).
- Pulses last exactly one cycle.
- Consumer sees at most one word per frame; max throughput one word per WIDTH+2 cycles.
- busy=1 from the edge sampling the start bit through the edge sampling the stop bit (exclusive).

## Configuration
- PARITY_CHECK_EN defined: PARITY state present, frame carries even-parity bit after data, parity_err active.
- Undefined: no PARITY state, frame = start + WIDTH data + stop, parity_err tied 0.

## Test plan
- WIDTH=4, no parity: svalid=1, send 1,1,0,1,0,1,1,1 (idle, idle, start, data 1,0,1,1, stop) → dout=4'hD, dout_valid=1 after stop edge, no error pulses.
- Stall: same frame with svalid=0 inserted between every bit, and sdata toggled during stalls → identical dout=4'hD, busy held high across stalls.
- Framing: start, data 0,1,1,0, stop=0 → frame_err one-cycle pulse, dout_valid stays 0, next frame (data 1,1,1,1) yields dout=4'hF.
- PARITY_CHECK_EN: data 1,0,1,1 with parity 1 → dout=4'hD; parity 0 → parity_err pulse, no dout_valid; stop=0 with bad parity → only frame_err.
- Overrun: two good frames 4'h3 then 4'h5 with dout_ready=0 → dout stays 4'h3, overrun pulse at second stop; repeat with dout_ready=1 at second stop edge → dout=4'h5, no overrun.
- Reset: assert clear after two data bits → busy=0, dout_valid=0; next full frame 4'hA received correctly.
